if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, requests instructions from instruction memory and presents
//  {instruction, PC+4} to the IF/ID register. Honours hazard stalls (hzdWrite) and branch/jump redirects,
//  raising if_flush so IF/ID squashes the wrong-path slot. Sits between imem and IF/ID.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  PC_STEP    4              sequential PC increment, in bytes
// PORTS
//  clk           in   1   pipeline clock; all state updates on negedge clk, matching the other pipeline regs
//  reset         in   1   asynchronous, active-low reset
//  hzdWrite      in   1   1 = downstream accepts this cycle; 0 = stall (hazard unit)
//  branchTaken   in   1   resolved branch is taken this cycle
//  branchTarget  in   32  branch target address
//  jump          in   1   jump decoded this cycle
//  jumpTarget    in   32  jump target address
//  imemReq       out  1   fetch request to instruction memory
//  imemAddr      out  32  fetch address (= current PC)
//  imemReady     in   1   imem data valid for imemAddr this cycle
//  imemData      in   32  instruction word from imem
//  instructionOut out 32  instruction to IF/ID (32'b0 = NOP bubble when not valid)
//  pcOut         out  32  PC+PC_STEP of instructionOut, to IF/ID
//  instrValid    out  1   instructionOut/pcOut are a real fetched instruction
//  if_flush      out  1   redirect this cycle; IF/ID must load a bubble
// BEHAVIOUR
//  Reset (asynchronous, active-low): pc=RESET_PC, state=FETCH, buffer=0. Outputs then: imemReq=1,
//   imemAddr=RESET_PC, instrValid=0, instructionOut=0, pcOut=0, if_flush=0.
//  States: FETCH (request outstanding), HELD (instruction buffered, waiting for hzdWrite).
//  FETCH: imemReq=1, imemAddr=pc. If imemReady, the instruction is valid this cycle:
//   instrValid=1, instructionOut=imemData, pcOut=pc+PC_STEP.
//  HELD: imemReq=0. instrValid=1, instructionOut=buffer, pcOut=pc+PC_STEP.
//  Transitions at negedge clk, in priority order:
//   1. redirect=branchTaken|jump: pc<=target, state<=FETCH, and any fetched/held word is dropped.
//      Target = branchTarget if branchTaken, else jumpTarget. Branch wins when both fire (older instr).
//      Target bits [1:0] are forced to 2'b00.
//   2. instrValid & hzdWrite: pc<=pc+PC_STEP, state<=FETCH.
//   3. FETCH & imemReady & !hzdWrite: buffer<=imemData, state<=HELD (no refetch while stalled).
//   4. otherwise: hold all state.
//  if_flush = redirect (combinational, same cycle). instrValid is forced to 0 while redirect=1.
//  Latency: zero-wait imem gives 1 instruction per cycle; each imem wait cycle adds one bubble.
//  A redirect during FETCH withdraws the request (imemAddr changes next cycle). imem is stateless
//   and tolerates withdrawn requests.
//  PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
//  Stall in HELD for any number of cycles: outputs stay stable and imem is not accessed.
//  Reset mid-fetch or mid-HELD: state drops immediately to the reset values; the buffer is discarded.
// CONFIGURATION
//  IF_FETCH_STATS_EN defined: adds outputs fetchCount[31:0] and stallCount[31:0], both reset to 0.
//   fetchCount increments on every rule-2 advance. stallCount increments each cycle with
//   instrValid & !hzdWrite, or with FETCH & !imemReady. Both saturate at 32'hFFFF_FFFF.
//  Undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package mips_pkg: state encoding (FETCH/HELD), NOP word 32'b0, default RESET_PC and PC_STEP.
//  One sub-module, if_next_pc: combinational next-PC select (redirect priority, alignment, increment).
// TESTING
//  1. Reset released, imemReady=1, hzdWrite=1: imemAddr 0,4,8,... on successive cycles; pcOut 4,8,12.
//  2. Instr at pc=8 valid, hzdWrite=0 for 3 cycles: state HELD, imemReq=0, instructionOut/pcOut=12 stable;
//     then hzdWrite=1 -> next imemAddr=12.
//  3. branchTaken=1, branchTarget=32'h40 and jump=1, jumpTarget=32'h80 in the same cycle: if_flush=1,
//     instrValid=0; next imemAddr=32'h40.
//  4. imemReady=0 for 2 cycles at pc=32'h10, then jump to 32'h83: request withdrawn, next imemAddr=32'h80.
//  5. pc=32'hFFFF_FFFC, advance -> imemAddr=0. reset asserted while HELD -> outputs at reset values at once.
//  6. IF_FETCH_STATS_EN: 5 fetches plus 2 stall cycles -> fetchCount=5, stallCount=2; reset clears both.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, NOP word, default PC reset value and step.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        FETCH = 1'b0,
        HELD  = 1'b1
    } fetch_state_t;

    localparam logic [XLEN-1:0] NOP_WORD         = '0;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned     DEFAULT_PC_STEP  = 4;

    // Word-align an address by clearing the byte-offset bits.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// imem request/response and IF/ID payload bundle for the fetch stage.
interface if_fetch_unit_if;
    import mips_pkg::*;

    logic            imemReq;
    logic [XLEN-1:0] imemAddr;
    logic            imemReady;
    logic [XLEN-1:0] imemData;
    logic [XLEN-1:0] instructionOut;
    logic [XLEN-1:0] pcOut;
    logic            instrValid;
    logic            if_flush;

    modport master (
        output imemReq, imemAddr, instructionOut, pcOut, instrValid, if_flush,
        input  imemReady, imemData
    );

    modport slave (
        input  imemReq, imemAddr, instructionOut, pcOut, instrValid, if_flush,
        output imemReady, imemData
    );

endinterface

// File: rtl/if_fetch_unit_next_pc.sv
// Combinational next-PC select: branch beats jump, targets word-aligned, sequential increment.
module if_next_pc
    import mips_pkg::*;
#(
    parameter int unsigned PC_STEP = DEFAULT_PC_STEP
) (
    input  logic [XLEN-1:0] pc,
    input  logic            branchTaken,
    input  logic [XLEN-1:0] branchTarget,
    input  logic            jump,
    input  logic [XLEN-1:0] jumpTarget,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_plus
);

    assign redirect    = branchTaken | jump;
    assign redirect_pc = align_word(branchTaken ? branchTarget : jumpTarget);
    assign pc_plus     = pc + XLEN'(PC_STEP);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from imem, buffers across stalls, honours redirects.
// Optional build macro IF_FETCH_STATS_EN adds fetchCount/stallCount saturating counters.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hzdWrite,
    input  logic            branchTaken,
    input  logic [XLEN-1:0] branchTarget,
    input  logic            jump,
    input  logic [XLEN-1:0] jumpTarget,
    if_fetch_unit_if.master bus
`ifdef IF_FETCH_STATS_EN
    ,
    output logic [XLEN-1:0] fetchCount,
    output logic [XLEN-1:0] stallCount
`endif
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] buffer;
    logic [XLEN-1:0] pc_plus;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect;
    logic            fetch_hit;
    logic            instr_valid;

    if_next_pc #(
        .PC_STEP (PC_STEP)
    ) u_next_pc (
        .pc           (pc),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .jump         (jump),
        .jumpTarget   (jumpTarget),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .pc_plus      (pc_plus)
    );

    assign fetch_hit   = (state == FETCH) & bus.imemReady;
    assign instr_valid = ((state == HELD) | fetch_hit) & ~redirect;

    // Pipeline state advances on the falling edge, like the other pipeline registers.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= RESET_PC;
            state  <= FETCH;
            buffer <= NOP_WORD;
        end else if (redirect) begin
            pc     <= redirect_pc;
            state  <= FETCH;
            buffer <= NOP_WORD;
        end else if (instr_valid && hzdWrite) begin
            pc    <= pc_plus;
            state <= FETCH;
        end else if (fetch_hit && !hzdWrite) begin
            buffer <= bus.imemData;
            state  <= HELD;
        end
    end

    assign bus.imemReq        = (state == FETCH);
    assign bus.imemAddr       = pc;
    assign bus.instrValid     = instr_valid;
    assign bus.instructionOut = !instr_valid   ? NOP_WORD :
                                (state == HELD) ? buffer   : bus.imemData;
    assign bus.pcOut          = instr_valid ? pc_plus : '0;
    assign bus.if_flush       = redirect;

`ifdef IF_FETCH_STATS_EN
    logic fetch_inc;
    logic stall_inc;

    assign fetch_inc = instr_valid & hzdWrite;
    assign stall_inc = (instr_valid & ~hzdWrite) | ((state == FETCH) & ~bus.imemReady);

    // Saturating performance counters.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            fetchCount <= '0;
            stallCount <= '0;
        end else begin
            if (fetch_inc && (fetchCount != '1)) fetchCount <= fetchCount + XLEN'(1);
            if (stall_inc && (stallCount != '1)) stallCount <= stallCount + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus queues expected IF/ID words, monitor checks handshakes.
module tb_if_fetch_unit;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic        hzd;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        rdy;
    logic [31:0] junk;

    int n_vec;
    int n_err;
    logic [63:0] exp_q[$];

    if_fetch_unit_if ifc ();

`ifdef IF_FETCH_STATS_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    if_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .hzdWrite     (hzd),
        .branchTaken  (br),
        .branchTarget (bt),
        .jump         (jmp),
        .jumpTarget   (jt),
        .bus          (ifc)
`ifdef IF_FETCH_STATS_EN
        ,
        .fetchCount   (fetch_cnt),
        .stallCount   (stall_cnt)
`endif
    );

    // Stateless imem: word derived from the address; junk corrupts it when imem must not be used.
    assign ifc.imemReady = rdy;
    assign ifc.imemData  = {ifc.imemAddr[15:0], 16'hC0DE} ^ junk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_imemReq",   32'(ifc.imemReq),    32'h1);
        chk("rst_imemAddr",  ifc.imemAddr,        32'h0);
        chk("rst_valid",     32'(ifc.instrValid), 32'h0);
        chk("rst_instr",     ifc.instructionOut,  32'h0);
        chk("rst_pcOut",     ifc.pcOut,           32'h0);
        chk("rst_flush",     32'(ifc.if_flush),   32'h0);
    endtask

    // One accepted fetch: expected IF/ID word goes to the scoreboard.
    task automatic expect_fetch(input logic [31:0] addr, input logic [31:0] instr, input logic [31:0] pcn);
        hzd = 1'b1;
        exp_q.push_back({instr, pcn});
        #1;
        chk("imemAddr", ifc.imemAddr, addr);
        tick();
    endtask

    // Monitor: every accepted IF/ID transfer pops one expectation.
    always @(posedge clk) begin
        if (reset === 1'b1 && ifc.instrValid === 1'b1 && hzd === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %h/%h expected no transfer", ifc.instructionOut, ifc.pcOut);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({ifc.instructionOut, ifc.pcOut} !== e) begin
                    n_err++;
                    $display("FAIL sb_transfer: got %h/%h expected %h/%h",
                             ifc.instructionOut, ifc.pcOut, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b0; hzd = 1'b1; br = 1'b0; bt = '0; jmp = 1'b0; jt = '0; rdy = 1'b0; junk = '0;
        tick();
        chk_reset_outputs();
`ifdef IF_FETCH_STATS_EN
        chk("rst_fetchCount", fetch_cnt, 32'h0);
        chk("rst_stallCount", stall_cnt, 32'h0);
`endif
        reset = 1'b1;
        rdy   = 1'b1;

        // Streaming fetch at one instruction per cycle
        expect_fetch(32'h0, 32'h0000_C0DE, 32'h4);
        expect_fetch(32'h4, 32'h0004_C0DE, 32'h8);

        // Stall at pc=8: buffer then hold with imem idle
        hzd = 1'b0;
        #1;
        chk("stall_addr",  ifc.imemAddr,        32'h8);
        chk("stall_valid", 32'(ifc.instrValid), 32'h1);
        tick();
        junk = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("held_req",   32'(ifc.imemReq),   32'h0);
            chk("held_instr", ifc.instructionOut, 32'h0008_C0DE);
            chk("held_pcOut", ifc.pcOut,          32'hC);
            tick();
        end
        hzd = 1'b1;
        exp_q.push_back({32'h0008_C0DE, 32'hC});
        #1;
        tick();
        junk = '0;

        // Branch and jump together: branch wins
        br = 1'b1; bt = 32'h40; jmp = 1'b1; jt = 32'h80;
        #1;
        chk("bj_addr",  ifc.imemAddr,        32'hC);
        chk("bj_flush", 32'(ifc.if_flush),   32'h1);
        chk("bj_valid", 32'(ifc.instrValid), 32'h0);
        tick();
        br = 1'b0; jmp = 1'b0;
        expect_fetch(32'h40, 32'h0040_C0DE, 32'h44);

        // imem wait states at 0x10, then misaligned jump withdraws the request
        jmp = 1'b1; jt = 32'h10;
        #1;
        chk("j10_flush", 32'(ifc.if_flush), 32'h1);
        tick();
        jmp = 1'b0; rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("wait_valid", 32'(ifc.instrValid), 32'h0);
            chk("wait_req",   32'(ifc.imemReq),    32'h1);
            chk("wait_addr",  ifc.imemAddr,        32'h10);
            tick();
        end
        jmp = 1'b1; jt = 32'h83;
        #1;
        chk("j83_flush", 32'(ifc.if_flush), 32'h1);
        tick();
        jmp = 1'b0; rdy = 1'b1;
        expect_fetch(32'h80, 32'h0080_C0DE, 32'h84);

        // PC wrap at top of address space
        jmp = 1'b1; jt = 32'hFFFF_FFFC;
        #1;
        tick();
        jmp = 1'b0;
        expect_fetch(32'hFFFF_FFFC, 32'hFFFC_C0DE, 32'h0);
        expect_fetch(32'h0, 32'h0000_C0DE, 32'h4);

        // Reset while HELD at pc=4 takes effect immediately
        hzd = 1'b0;
        #1;
        tick();
        #1;
        chk("pre_rst_req", 32'(ifc.imemReq), 32'h0);
        rdy   = 1'b0;
        reset = 1'b0;
        #1;
        chk_reset_outputs();
        tick();
        reset = 1'b1; rdy = 1'b1;

        // Five fetches then two stall cycles
        expect_fetch(32'h0,  32'h0000_C0DE, 32'h4);
        expect_fetch(32'h4,  32'h0004_C0DE, 32'h8);
        expect_fetch(32'h8,  32'h0008_C0DE, 32'hC);
        expect_fetch(32'hC,  32'h000C_C0DE, 32'h10);
        expect_fetch(32'h10, 32'h0010_C0DE, 32'h14);
        hzd = 1'b0;
        tick();
        tick();
        chk("post_rst_held", ifc.instructionOut, 32'h0014_C0DE);
`ifdef IF_FETCH_STATS_EN
        chk("fetchCount", fetch_cnt, 32'h5);
        chk("stallCount", stall_cnt, 32'h2);
`endif
        hzd = 1'b1;
        exp_q.push_back({32'h0014_C0DE, 32'h18});
        #1;
        tick();
        rdy   = 1'b0;
        reset = 1'b0;
        #1;
`ifdef IF_FETCH_STATS_EN
        chk("clr_fetchCount", fetch_cnt, 32'h0);
        chk("clr_stallCount", stall_cnt, 32'h0);
`endif
        chk("clr_imemAddr", ifc.imemAddr, 32'h0);
        tick();
        chk("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
